// File: rtl/spi_regbank_pkg.sv
// Shared types and constants for the SPI register-bank slave.
package spi_regbank_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CMD  = 2'd1;
  localparam state_t DATA = 2'd2;
  localparam state_t DONE = 2'd3;

  localparam int unsigned CMD_W      = 8;
  localparam int unsigned WR_BIT     = 7;
  localparam int unsigned STAT_CNT_W = 16;

  // Saturating increment for the status counters.
  function automatic logic [STAT_CNT_W-1:0] sat_inc(input logic [STAT_CNT_W-1:0] v);
    return (&v) ? v : v + STAT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with single-clk rise/fall pulses on the synchronised level.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise_c = sync & ~prev;
  assign fall_c = ~sync & prev;

endmodule

// File: rtl/spi_regbank_slave.sv
// SPI slave register bank: 8-bit command then DATA_W data bits, MSB first, any CPOL/CPHA.
// Optional read-only status register at the top address when SPI_REGBANK_STATUS_EN is defined.
module spi_regbank_slave
  import spi_regbank_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned N_MOSI = 16,
  parameter int unsigned N_MISO = 16,
  parameter logic        CPOL   = 1'b0,
  parameter logic        CPHA   = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     spi_clk,
  input  logic                     spi_cs_n,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  input  logic [N_MISO*DATA_W-1:0] miso_data,
  output logic [N_MOSI*DATA_W-1:0] mosi_data,
  output logic [N_MOSI-1:0]        mosi_wr_stb,
  output logic                     frame_done,
  output logic                     frame_abort
);

  localparam int unsigned FRAME_W   = CMD_W + DATA_W;
  localparam int unsigned CNT_W     = $clog2(FRAME_W + 1);
  localparam int unsigned STAT_ADDR = (1 << ADDR_W) - 1;

  logic sclk_rise_c, sclk_fall_c, cs_rise_c, cs_fall_c;
  logic sample_c, shift_c;
  logic mosi_meta, mosi_s;

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           bit_cnt, bit_cnt_nxt;
  logic [CMD_W-1:0]           cmd_sr, cmd_nxt;
  logic [DATA_W-2:0]          rx_sr, rx_nxt;
  logic [DATA_W-1:0]          tx_sr, tx_nxt;
  logic                       miso_nxt;
  logic [N_MOSI*DATA_W-1:0]   data_nxt;
  logic [N_MOSI-1:0]          stb_nxt;
  logic                       done_nxt, abort_nxt;

  logic [CMD_W-1:0]           cmd_shift_c;
  logic [ADDR_W-1:0]          rd_addr_c, wr_addr_c;
  logic [DATA_W-1:0]          rd_word_c, wr_data_c;
  logic                       wr_en_c;

  spi_sync_edge #(.RST_VAL(CPOL)) u_sclk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (spi_clk),
    .rise_c  (sclk_rise_c),
    .fall_c  (sclk_fall_c)
  );

  // Resetting to 0 means no frame starts until CS has first been seen high, then low.
  spi_sync_edge #(.RST_VAL(1'b0)) u_cs_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (spi_cs_n),
    .rise_c  (cs_rise_c),
    .fall_c  (cs_fall_c)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      mosi_meta <= spi_mosi;
      mosi_s    <= mosi_meta;
    end
  end

  // Leading edge is rising for CPOL=0; CPHA=1 moves sampling to the trailing edge.
  assign sample_c = (CPOL ^ CPHA) ? sclk_fall_c : sclk_rise_c;
  assign shift_c  = (CPOL ^ CPHA) ? sclk_rise_c : sclk_fall_c;

  assign cmd_shift_c = {cmd_sr[CMD_W-2:0], mosi_s};
  assign rd_addr_c   = cmd_shift_c[ADDR_W-1:0];
  assign wr_addr_c   = cmd_sr[ADDR_W-1:0];
  assign wr_data_c   = {rx_sr, mosi_s};

`ifdef SPI_REGBANK_STATUS_EN
  logic [STAT_CNT_W-1:0] frame_cnt, abort_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      abort_cnt <= '0;
    end else begin
      if (frame_done)  frame_cnt <= sat_inc(frame_cnt);
      if (frame_abort) abort_cnt <= sat_inc(abort_cnt);
    end
  end

  assign wr_en_c = cmd_sr[WR_BIT] && (32'(wr_addr_c) < N_MOSI) &&
                   (wr_addr_c != ADDR_W'(STAT_ADDR));
`else
  assign wr_en_c = cmd_sr[WR_BIT] && (32'(wr_addr_c) < N_MOSI);
`endif

  // Read mux; unmapped addresses return zero.
  always_comb begin
    rd_word_c = '0;
    for (int i = 0; i < N_MISO; i++) begin
      if (ADDR_W'(i) == rd_addr_c) rd_word_c = miso_data[i*DATA_W +: DATA_W];
    end
`ifdef SPI_REGBANK_STATUS_EN
    if (rd_addr_c == ADDR_W'(STAT_ADDR)) rd_word_c = DATA_W'({frame_cnt, abort_cnt});
`endif
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    cmd_nxt     = cmd_sr;
    rx_nxt      = rx_sr;
    tx_nxt      = tx_sr;
    miso_nxt    = spi_miso;
    data_nxt    = mosi_data;
    stb_nxt     = '0;
    done_nxt    = 1'b0;
    abort_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (cs_fall_c) begin
          state_nxt   = CMD;
          bit_cnt_nxt = '0;
          cmd_nxt     = '0;
          rx_nxt      = '0;
          tx_nxt      = '0;
          miso_nxt    = 1'b0;
        end
      end
      CMD: begin
        if (cs_rise_c) begin
          state_nxt = IDLE;
          abort_nxt = 1'b1;
          miso_nxt  = 1'b0;
        end else if (sample_c) begin
          cmd_nxt     = cmd_shift_c;
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(CMD_W - 1)) begin
            tx_nxt    = rd_word_c;
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (cs_rise_c) begin
          state_nxt = IDLE;
          abort_nxt = 1'b1;
          miso_nxt  = 1'b0;
        end else if (shift_c) begin
          miso_nxt = tx_sr[DATA_W-1];
          tx_nxt   = {tx_sr[DATA_W-2:0], 1'b0};
        end else if (sample_c) begin
          rx_nxt      = wr_data_c[DATA_W-2:0];
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            for (int i = 0; i < N_MOSI; i++) begin
              if (wr_en_c && (wr_addr_c == ADDR_W'(i))) begin
                data_nxt[i*DATA_W +: DATA_W] = wr_data_c;
                stb_nxt[i]                   = 1'b1;
              end
            end
          end
        end
      end
      DONE: begin
        if (cs_rise_c) begin
          state_nxt = IDLE;
          miso_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      cmd_sr      <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      spi_miso    <= 1'b0;
      mosi_data   <= '0;
      mosi_wr_stb <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      cmd_sr      <= cmd_nxt;
      rx_sr       <= rx_nxt;
      tx_sr       <= tx_nxt;
      spi_miso    <= miso_nxt;
      mosi_data   <= data_nxt;
      mosi_wr_stb <= stb_nxt;
      frame_done  <= done_nxt;
      frame_abort <= abort_nxt;
    end
  end

endmodule

// File: tb/tb_spi_regbank_slave.sv
// Directed bench: mode-0 instance (16 write / 15 read regs) and mode-3 instance (4/4 regs).
module tb_spi_regbank_slave;

  localparam int HALF = 50;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mosi = 1'b0;
  logic sclk0 = 1'b0, cs0 = 1'b1, miso0;
  logic sclk1 = 1'b1, cs1 = 1'b1, miso1;

  logic [15*32-1:0] miso_data0;
  logic [16*32-1:0] mosi_data0;
  logic [15:0]      stb0;
  logic             done0, abort0;

  logic [4*32-1:0]  miso_data1;
  logic [4*32-1:0]  mosi_data1;
  logic [3:0]       stb1;
  logic             done1, abort1;

  int n_checks = 0;
  int n_fail   = 0;

  int done_n0 = 0, abort_n0 = 0, stb_cyc0 = 0;
  int done_n1 = 0, abort_n1 = 0, stb_cyc1 = 0;
  logic [15:0] stb_last0 = '0, stb_last1 = '0;

  always #5 clk = ~clk;

  spi_regbank_slave #(
    .DATA_W(32), .ADDR_W(4), .N_MOSI(16), .N_MISO(15), .CPOL(1'b0), .CPHA(1'b0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .spi_clk(sclk0), .spi_cs_n(cs0), .spi_mosi(mosi),
    .spi_miso(miso0), .miso_data(miso_data0), .mosi_data(mosi_data0),
    .mosi_wr_stb(stb0), .frame_done(done0), .frame_abort(abort0)
  );

  spi_regbank_slave #(
    .DATA_W(32), .ADDR_W(4), .N_MOSI(4), .N_MISO(4), .CPOL(1'b1), .CPHA(1'b1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .spi_clk(sclk1), .spi_cs_n(cs1), .spi_mosi(mosi),
    .spi_miso(miso1), .miso_data(miso_data1), .mosi_data(mosi_data1),
    .mosi_wr_stb(stb1), .frame_done(done1), .frame_abort(abort1)
  );

  // Pulse monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (done0)  done_n0++;
    if (abort0) abort_n0++;
    if (stb0 != '0) begin stb_cyc0++; stb_last0 = stb0; end
    if (done1)  done_n1++;
    if (abort1) abort_n1++;
    if (stb1 != '0) begin stb_cyc1++; stb_last1 = {12'h000, stb1}; end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic spi_bit(input int which, input logic b, output logic rx);
    if (which == 0) begin
      mosi = b; #HALF; rx = miso0; sclk0 = 1'b1; #HALF; sclk0 = 1'b0;
    end else begin
      sclk1 = 1'b0; mosi = b; #HALF; rx = miso1; sclk1 = 1'b1; #HALF;
    end
  endtask

  task automatic set_cs(input int which, input logic v);
    if (which == 0) cs0 = v; else cs1 = v;
  endtask

  task automatic spi_xfer(input int which, input logic [7:0] cmd, input logic [31:0] data,
                          input int nbits, output logic [39:0] rx);
    logic [39:0] frame;
    logic b;
    frame = {cmd, data};
    rx = '0;
    set_cs(which, 1'b0);
    #HALF;
    for (int i = 0; i < nbits; i++) begin
      spi_bit(which, frame[39-i], b);
      rx = {rx[38:0], b};
    end
    #HALF;
    set_cs(which, 1'b1);
    repeat (20) @(negedge clk);
  endtask

  task automatic get_counts(input int which, output int d, output int a, output int s,
                            output logic [15:0] last);
    if (which == 0) begin d = done_n0; a = abort_n0; s = stb_cyc0; last = stb_last0; end
    else            begin d = done_n1; a = abort_n1; s = stb_cyc1; last = stb_last1; end
  endtask

  typedef struct {
    int          which;
    logic [7:0]  cmd;
    logic [31:0] data;
    int          nbits;
    logic        exp_done;
    logic        exp_abort;
    logic [15:0] exp_stb;
    logic [31:0] exp_rd;
    int          reg_idx;
    logic [31:0] exp_reg;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [39:0] rx, exp_rx;
    logic [15:0] last;
    logic [31:0] reg_val;
    logic b;
    int d0, a0, s0, d1, a1, s1;
    int good0, ab0;
    logic [39:0] frame;

    vecs[0]  = '{0, 8'h81, 32'hDEADBEEF, 40, 1'b1, 1'b0, 16'h0002, 32'h01010101, 1, 32'hDEADBEEF};
    vecs[1]  = '{0, 8'h03, 32'h00000000, 40, 1'b1, 1'b0, 16'h0000, 32'h12345678, 1, 32'hDEADBEEF};
    vecs[2]  = '{0, 8'h85, 32'hCAFEF00D, 20, 1'b0, 1'b1, 16'h0000, 32'h05050505, 5, 32'h00000000};
    vecs[3]  = '{0, 8'h85, 32'hCAFEF00D, 40, 1'b1, 1'b0, 16'h0020, 32'h05050505, 5, 32'hCAFEF00D};
    vecs[4]  = '{0, 8'h0E, 32'h00000000, 40, 1'b1, 1'b0, 16'h0000, 32'h0E0E0E0E, 5, 32'hCAFEF00D};
    vecs[5]  = '{1, 8'h81, 32'hDEADBEEF, 40, 1'b1, 1'b0, 16'h0002, 32'h01010101, 1, 32'hDEADBEEF};
    vecs[6]  = '{1, 8'h03, 32'h00000000, 40, 1'b1, 1'b0, 16'h0000, 32'h12345678, 1, 32'hDEADBEEF};
    vecs[7]  = '{1, 8'h89, 32'h11112222, 40, 1'b1, 1'b0, 16'h0000, 32'h00000000, 1, 32'hDEADBEEF};
    vecs[8]  = '{1, 8'h09, 32'h00000000, 40, 1'b1, 1'b0, 16'h0000, 32'h00000000, 1, 32'hDEADBEEF};
    vecs[9]  = '{1, 8'h82, 32'h0BADF00D, 39, 1'b0, 1'b1, 16'h0000, 32'h02020202, 2, 32'h00000000};
    vecs[10] = '{1, 8'h82, 32'h0BADF00D, 40, 1'b1, 1'b0, 16'h0004, 32'h02020202, 2, 32'h0BADF00D};
    vecs[11] = '{0, 8'h8A, 32'h5555AAAA,  8, 1'b0, 1'b1, 16'h0000, 32'h0A0A0A0A, 10, 32'h00000000};

    for (int i = 0; i < 15; i++) miso_data0[i*32 +: 32] = {4{8'(i)}};
    for (int i = 0; i < 4; i++)  miso_data1[i*32 +: 32] = {4{8'(i)}};
    miso_data0[3*32 +: 32] = 32'h12345678;
    miso_data1[3*32 +: 32] = 32'h12345678;

    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    check("reset mosi_data0", 64'(|mosi_data0), 64'd0);
    check("reset mosi_data1", 64'(|mosi_data1), 64'd0);
    check("reset miso", {62'd0, miso0, miso1}, 64'd0);
    check("reset pulses", 64'(done_n0 + abort_n0 + stb_cyc0 + done_n1 + abort_n1 + stb_cyc1), 64'd0);

    // Reset mid-frame with CS left low: the remainder of that frame must be ignored.
    get_counts(0, d0, a0, s0, last);
    frame = {8'h81, 32'hFFFF0000};
    cs0 = 1'b0;
    #HALF;
    for (int i = 0; i < 12; i++) spi_bit(0, frame[39-i], b);
    @(negedge clk) reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 12; i < 40; i++) spi_bit(0, frame[39-i], b);
    #HALF;
    cs0 = 1'b1;
    repeat (20) @(negedge clk);
    get_counts(0, d1, a1, s1, last);
    check("midreset done", 64'(d1 - d0), 64'd0);
    check("midreset abort", 64'(a1 - a0), 64'd0);
    check("midreset stb", 64'(s1 - s0), 64'd0);
    check("midreset reg1", mosi_data0[1*32 +: 32], 64'd0);
    check("midreset miso", 64'(miso0), 64'd0);

    good0 = 0;
    ab0   = 0;
    for (int i = 0; i < 12; i++) begin
      get_counts(vecs[i].which, d0, a0, s0, last);
      spi_xfer(vecs[i].which, vecs[i].cmd, vecs[i].data, vecs[i].nbits, rx);
      get_counts(vecs[i].which, d1, a1, s1, last);
      exp_rx = {8'h00, vecs[i].exp_rd} >> (40 - vecs[i].nbits);
      reg_val = (vecs[i].which == 0) ? mosi_data0[vecs[i].reg_idx*32 +: 32]
                                     : mosi_data1[vecs[i].reg_idx*32 +: 32];
      check($sformatf("v%0d done", i), 64'(d1 - d0), 64'(vecs[i].exp_done));
      check($sformatf("v%0d abort", i), 64'(a1 - a0), 64'(vecs[i].exp_abort));
      check($sformatf("v%0d stb_cycles", i), 64'(s1 - s0), 64'(vecs[i].exp_stb != '0));
      if (vecs[i].exp_stb != '0) check($sformatf("v%0d stb_mask", i), 64'(last), 64'(vecs[i].exp_stb));
      check($sformatf("v%0d miso", i), 64'(rx), 64'(exp_rx));
      check($sformatf("v%0d reg%0d", i, vecs[i].reg_idx), 64'(reg_val), 64'(vecs[i].exp_reg));
      if (vecs[i].which == 0) begin
        good0 += int'(vecs[i].exp_done);
        ab0   += int'(vecs[i].exp_abort);
      end
    end

    spi_xfer(0, 8'h0F, 32'h0, 40, rx);
`ifdef SPI_REGBANK_STATUS_EN
    check("status read", 64'(rx), 64'({8'h00, 16'(good0), 16'(ab0)}));
`else
    check("unmapped read 0x0F", 64'(rx), 64'd0);
    check("frame tally", 64'(done_n0), 64'(good0 + 1));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
